// File: rtl/cam_pad.sv
// cam_pad: re-embeds a cropped window into a full FRAME_W x FRAME_H raster with a constant border.
// Outputs registered; first raster pixel 2 cycles after start of frame; raster stalls in-window on an empty FIFO.

module cam_pad_fifo #(
   parameter int W     = 30,
   parameter int DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_vld_i,
   input  logic [W-1:0] wr_dat_i,
   input  logic         rd_i,
   output logic [W-1:0] rd_dat_o,
   output logic         empty_o,
   output logic         drop_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          do_rd, do_wr;

   assign do_rd    = rd_i && (cnt_q != '0);
   // A full FIFO still accepts a write when a read frees a slot in the same cycle.
   assign do_wr    = wr_vld_i && ((cnt_q != FULL_CNT) || do_rd);
   assign drop_o   = wr_vld_i && !do_wr;
   assign empty_o  = (cnt_q == '0);
   assign rd_dat_o = mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wptr_q] <= wr_dat_i;
   end
endmodule

module cam_pad #(
   parameter int P_DEPTH    = 10,
   parameter int FRAME_W    = 16,
   parameter int FRAME_H    = 8,
   parameter int X_START    = 0,
   parameter int X_WIN      = 8,
   parameter int Y_START    = 0,
   parameter int Y_WIN      = 4,
   parameter int H_GAP      = 4,
   parameter int FILL       = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic               in_pclk,
   input  logic               in_rst,
   input  logic [10:0]        in_x,
   input  logic [10:0]        in_y,
   input  logic               in_valid,
   input  logic [P_DEPTH-1:0] in_data_00,
   input  logic [P_DEPTH-1:0] in_data_01,
   input  logic [P_DEPTH-1:0] in_data_10,
   output logic [10:0]        out_x,
   output logic [10:0]        out_y,
   output logic               out_valid,
   output logic               out_hs,
   output logic [P_DEPTH-1:0] out_data_00,
   output logic [P_DEPTH-1:0] out_data_01,
   output logic [P_DEPTH-1:0] out_data_10,
   output logic               out_ovf,
   output logic               out_sof_err
);
   localparam int DW = 3 * P_DEPTH;
   localparam int GW = (H_GAP > 1) ? $clog2(H_GAP) : 1;
   localparam logic [10:0] XS    = 11'(X_START);
   localparam logic [10:0] YS    = 11'(Y_START);
   localparam logic [10:0] XW    = 11'(X_WIN);
   localparam logic [10:0] YW    = 11'(Y_WIN);
   localparam logic [10:0] XLAST = 11'(FRAME_W - 1);
   localparam logic [10:0] YLAST = 11'(FRAME_H - 1);
   localparam logic [GW-1:0] GLAST = GW'((H_GAP > 0) ? H_GAP - 1 : 0);
   localparam logic [P_DEPTH-1:0] FILL_V = P_DEPTH'(FILL);

   typedef enum logic [1:0] {S_IDLE, S_LINE, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [10:0]   rx_q, rx_d, ry_q, ry_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [10:0]   x_q, x_d, y_q, y_d;
   logic          vld_q, vld_d, hs_q, hs_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          ovf_q, ovf_d, sof_err_q, sof_err_d;

   logic          win_px, sof_px, in_win, fifo_rd, fifo_empty, fifo_drop;
   logic [DW-1:0] fifo_rdat;

   assign win_px = in_valid && (in_x < XW) && (in_y < YW);
   assign sof_px = in_valid && (in_x == '0) && (in_y == '0);
   // Offset subtraction wraps for positions left of / above the window, so one compare covers both bounds.
   assign in_win = ((rx_q - XS) < XW) && ((ry_q - YS) < YW);

   cam_pad_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i    (in_pclk),
      .rst_i    (in_rst),
      .wr_vld_i (win_px),
      .wr_dat_i ({in_data_00, in_data_01, in_data_10}),
      .rd_i     (fifo_rd),
      .rd_dat_o (fifo_rdat),
      .empty_o  (fifo_empty),
      .drop_o   (fifo_drop)
   );

   always_comb begin
      state_d   = state_q;
      rx_d      = rx_q;
      ry_d      = ry_q;
      gap_d     = gap_q;
      x_d       = x_q;
      y_d       = y_q;
      dat_d     = dat_q;
      vld_d     = 1'b0;
      hs_d      = 1'b0;
      fifo_rd   = 1'b0;
      ovf_d     = ovf_q | fifo_drop;
      sof_err_d = sof_err_q | (sof_px && (state_q != S_IDLE));
      case (state_q)
         S_IDLE: begin
            if (sof_px) begin
               state_d = S_LINE;
               rx_d    = '0;
               ry_d    = '0;
            end
         end
         S_LINE: begin
            hs_d = 1'b1;
            if (in_win) begin
               if (!fifo_empty) begin
                  fifo_rd = 1'b1;
                  vld_d   = 1'b1;
                  dat_d   = fifo_rdat;
               end
            end else begin
               vld_d = 1'b1;
               dat_d = {3{FILL_V}};
            end
            if (vld_d) begin
               x_d = rx_q;
               y_d = ry_q;
               if (rx_q == XLAST) begin
                  rx_d = '0;
                  if (ry_q == YLAST) begin
                     state_d = S_IDLE;
                  end else begin
                     ry_d    = ry_q + 11'd1;
                     gap_d   = '0;
                     state_d = (H_GAP == 0) ? S_LINE : S_GAP;
                  end
               end else begin
                  rx_d = rx_q + 11'd1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GLAST) state_d = S_LINE;
            else                gap_d   = gap_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_pclk) begin
      if (in_rst) begin
         state_q   <= S_IDLE;
         rx_q      <= '0;
         ry_q      <= '0;
         gap_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         vld_q     <= 1'b0;
         hs_q      <= 1'b0;
         dat_q     <= '0;
         ovf_q     <= 1'b0;
         sof_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_q      <= rx_d;
         ry_q      <= ry_d;
         gap_q     <= gap_d;
         x_q       <= x_d;
         y_q       <= y_d;
         vld_q     <= vld_d;
         hs_q      <= hs_d;
         dat_q     <= dat_d;
         ovf_q     <= ovf_d;
         sof_err_q <= sof_err_d;
      end
   end

   assign out_x       = x_q;
   assign out_y       = y_q;
   assign out_valid   = vld_q;
   assign out_hs      = hs_q;
   assign out_data_00 = dat_q[DW-1 -: P_DEPTH];
   assign out_data_01 = dat_q[P_DEPTH +: P_DEPTH];
   assign out_data_10 = dat_q[P_DEPTH-1:0];
   assign out_ovf     = ovf_q;
   assign out_sof_err = sof_err_q;
endmodule
